ocra1_rx: RTL

Synthesizable receiver for the OCRA1 four-channel serial DAC link: the far end of the `ocra1_iface` transmitter. It oversamples the link with its own system clock, deserializes four parallel 24-bit frames (x, y, z, z2), decodes DAC-register writes into per-channel 18-bit holding registers, and transfers them to the outputs on LDAC. It serves as a loopback checker on the FPGA and as the synthesizable replacement for the behavioural board model in system benches.

---
 rtl/ocra1_rx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ocra1_rx.sv
// rtl/ocra1_rx.sv - OCRA1 four-channel serial DAC link receiver
// Oversamples the link, deserializes 24-bit frames, decodes DAC writes and loads vout on LDAC.
module ocra1_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        oc1_clk_i,
    input  logic        oc1_syncn_i,
    input  logic        oc1_ldacn_i,
    input  logic        oc1_sdox_i,
    input  logic        oc1_sdoy_i,
    input  logic        oc1_sdoz_i,
    input  logic        oc1_sdoz2_i,
    output logic [23:0] datax_o,
    output logic [23:0] datay_o,
    output logic [23:0] dataz_o,
    output logic [23:0] dataz2_o,
    output logic        valid_o,
    output logic        frame_err_o,
    output logic [17:0] voutx_o,
    output logic [17:0] vouty_o,
    output logic [17:0] voutz_o,
    output logic [17:0] voutz2_o,
    output logic        ldac_o
);

    localparam int CW = $clog2(FRAME_BITS + 2);
    // Bit order: 0 sclk, 1 syncn, 2 ldacn, 3..6 sdo x/y/z/z2; framing strobes idle high
    localparam logic [6:0] SYNC_RST = 7'b000_0110;

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [6:0]    sync_q [SYNC_STAGES];
    logic [6:0]    prev_q;
    logic [6:0]    lvl;
    logic          sclk_fall, syncn_fall, syncn_rise, ldacn_fall;
    state_t        state, state_d;
    logic          start, shift_en, close;
    logic [CW-1:0] cnt;
    logic [23:0]   sr   [4];
    logic [23:0]   data [4];
    logic [17:0]   hold [4];
    logic [17:0]   vout [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
            prev_q <= SYNC_RST;
        end else begin
            sync_q[0] <= {oc1_sdoz2_i, oc1_sdoz_i, oc1_sdoy_i, oc1_sdox_i,
                          oc1_ldacn_i, oc1_syncn_i, oc1_clk_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl        = sync_q[SYNC_STAGES-1];
    assign sclk_fall  = prev_q[0] & ~lvl[0];
    assign syncn_fall = prev_q[1] & ~lvl[1];
    assign syncn_rise = ~prev_q[1] & lvl[1];
    assign ldacn_fall = prev_q[2] & ~lvl[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // A SCLK fall coinciding with the closing SYNCN edge is dropped, not counted
    always_comb begin
        state_d  = state;
        start    = 1'b0;
        shift_en = 1'b0;
        close    = 1'b0;
        case (state)
            IDLE: begin
                if (syncn_fall) begin
                    start   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (syncn_rise) begin
                    close   = 1'b1;
                    state_d = IDLE;
                end else if (sclk_fall) begin
                    shift_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            ldac_o      <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                sr[c]   <= '0;
                data[c] <= '0;
                hold[c] <= '0;
                vout[c] <= '0;
            end
        end else begin
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            ldac_o      <= 1'b0;
            if (start) begin
                cnt <= '0;
                for (int c = 0; c < 4; c++) sr[c] <= '0;
            end else if (shift_en) begin
                for (int c = 0; c < 4; c++) sr[c] <= {sr[c][22:0], lvl[3+c]};
                if (cnt != CW'(FRAME_BITS + 1)) cnt <= cnt + 1'b1;
            end
            if (close) begin
                if (cnt == CW'(FRAME_BITS)) begin
                    valid_o <= 1'b1;
                    for (int c = 0; c < 4; c++) begin
                        data[c] <= sr[c];
                        if (sr[c][23:20] == 4'b0001) hold[c] <= sr[c][19:2];
                    end
                end else begin
                    frame_err_o <= 1'b1;
                end
            end
            // Nonblocking read of hold: a same-cycle frame close is not yet visible here
            if (ldacn_fall) begin
                ldac_o <= 1'b1;
                for (int c = 0; c < 4; c++) vout[c] <= hold[c];
            end
        end
    end

    assign datax_o  = data[0];
    assign datay_o  = data[1];
    assign dataz_o  = data[2];
    assign dataz2_o = data[3];
    assign voutx_o  = vout[0];
    assign vouty_o  = vout[1];
    assign voutz_o  = vout[2];
    assign voutz2_o = vout[3];

endmodule
